// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv_pipeline front end.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush overrides push/pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch front end: PC generation, credit-limited imem requests,
// in-order response buffering and redirect handling.
module riscv_fetch_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_init,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import riscv_pkg::fetch_entry_t;
    import riscv_pkg::INSTR_BYTES;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wdata;

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            push;
    logic            pop;

    assign credit_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign target         = {redirect_pc[XLEN-1:2], 2'b00};

    assign accept = imem_req_valid && imem_req_ready;
    assign push   = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign if_valid = !fifo_empty && !redirect_valid;
    assign pop    = if_valid && if_ready;

    assign fifo_wdata.pc    = resp_pc_q;
    assign fifo_wdata.instr = imem_resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= pc_init;
            resp_pc_q  <= pc_init;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(accept) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Every response still owed, minus the one arriving now, is stale.
                pc_q      <= target;
                resp_pc_q <= target;
                drop_q    <= inflight_q - CW'(imem_resp_valid);
            end else begin
                if (accept) begin
                    pc_q <= pc_q + XLEN'(INSTR_BYTES);
                end
                if (imem_resp_valid) begin
                    if (drop_q != '0) begin
                        drop_q <= drop_q - CW'(1);
                    end else begin
                        resp_pc_q <= resp_pc_q + XLEN'(INSTR_BYTES);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign if_pc    = fifo_head.pc;
    assign if_instr = fifo_head.instr;

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Randomized bench for riscv_fetch_stage with an imem model and a queue-based
// reference of the delivered instruction stream.
module tb_riscv_fetch_stage;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_init;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    riscv_fetch_stage #(
        .XLEN  (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_init         (pc_init),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] deliv_q[$];
    int          deliv_cyc_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] mpc;
    logic [31:0] mresp_pc;
    int          mdrop;
    int          lat_mode;
    int          rdy_pct;
    int          ifr_pct;
    int          redir_mode;
    bit          redir_req;
    logic [31:0] redir_tgt;
    bit          first_chk;
    logic [31:0] first_exp;
    bit          post_redir;
    int          accepts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of stimulus, checking and model update.
    task automatic step();
        bit   resp, redir, exp_rv, exp_iv, acc, pop;
        req_t r;
        @(negedge clk);
        resp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? (mem_q[0].addr ^ KEY) : 32'h0;
        imem_req_ready  = ($urandom_range(99) < rdy_pct);
        if_ready        = ($urandom_range(99) < ifr_pct);
        redir = redir_req && ((redir_mode == 0) || (resp && buf_q.size() > 0 && if_ready));
        redirect_valid  = redir;
        redirect_pc     = redir ? redir_tgt : $urandom;
        #1;
        if (post_redir) begin
            check("flush_empty", {31'b0, if_valid}, 32'd0);
            post_redir = 0;
        end
        exp_rv = !redir && (mem_q.size() + buf_q.size() < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, mpc);
        exp_iv = !redir && (buf_q.size() > 0);
        check("if_valid", {31'b0, if_valid}, {31'b0, exp_iv});
        if (exp_iv) begin
            check("if_pc", if_pc, buf_q[0]);
            check("if_instr", if_instr, buf_q[0] ^ KEY);
        end
        acc = exp_rv && imem_req_ready;
        pop = exp_iv && if_ready;
        if (pop) begin
            if (first_chk) begin
                check("first_after_restart", if_pc, first_exp);
                first_chk = 0;
            end
            deliv_q.push_back(buf_q[0]);
            deliv_cyc_q.push_back(cyc);
        end
        if (resp) r = mem_q.pop_front();
        if (redir) begin
            mdrop      = mem_q.size();
            buf_q.delete();
            mpc        = {redir_tgt[31:2], 2'b00};
            mresp_pc   = mpc;
            redir_req  = 0;
            first_chk  = 1;
            first_exp  = mpc;
            post_redir = 1;
        end else begin
            if (resp) begin
                if (mdrop > 0) mdrop--;
                else begin
                    buf_q.push_back(mresp_pc);
                    mresp_pc += 32'd4;
                end
            end
            if (pop) void'(buf_q.pop_front());
            if (acc) begin
                r.addr = mpc;
                r.due  = cyc + ((lat_mode == 0) ? int'($urandom_range(3, 1)) : lat_mode);
                mem_q.push_back(r);
                mpc += 32'd4;
                accepts++;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    // Asserts reset at a negedge (async), checks reset outputs for 3 cycles, releases.
    task automatic do_reset(input logic [31:0] init);
        @(negedge clk);
        reset           = 1'b1;
        pc_init         = init;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        mem_q.delete();
        buf_q.delete();
        mdrop      = 0;
        mpc        = init;
        mresp_pc   = init;
        redir_req  = 0;
        post_redir = 0;
        first_chk  = 1;
        first_exp  = init;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("rst_if_valid", {31'b0, if_valid}, 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_instr", if_instr, 32'd0);
            check("rst_req_addr", imem_req_addr, init);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic wait_inflight2(input string tag);
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
        check(tag, mem_q.size(), 32'd2);
    endtask

    task automatic clear_log();
        deliv_q.delete();
        deliv_cyc_q.delete();
    endtask

    task automatic check_deliv(input string tag, input int idx, input logic [31:0] exp);
        if (deliv_q.size() > idx) check(tag, deliv_q[idx], exp);
        else check({tag, "_missing"}, deliv_q.size(), idx + 1);
    endtask

    initial begin
        reset = 1'b1; pc_init = 32'h100; imem_req_ready = 0; imem_resp_valid = 0;
        imem_resp_data = 0; if_ready = 0; redirect_valid = 0; redirect_pc = 0;
        redir_mode = 0; lat_mode = 1; rdy_pct = 100; ifr_pct = 100; accepts = 0;

        // 1: streaming with 1-cycle memory
        do_reset(32'h100);
        clear_log();
        repeat (8) step();
        check_deliv("t1_pc0", 0, 32'h100);
        check_deliv("t1_pc1", 1, 32'h104);
        check_deliv("t1_pc2", 2, 32'h108);
        if (deliv_cyc_q.size() >= 2)
            check("t1_back_to_back", deliv_cyc_q[1] - deliv_cyc_q[0], 32'd1);

        // 2: decode stall limits outstanding work to DEPTH
        do_reset(32'h100);
        ifr_pct = 0; accepts = 0;
        repeat (6) step();
        check("t2_accepts", accepts, DEPTH);
        check("t2_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        ifr_pct = 100;
        clear_log();
        repeat (8) step();
        check_deliv("t2_pc0", 0, 32'h100);
        check_deliv("t2_pc1", 1, 32'h104);
        check_deliv("t2_pc2", 2, 32'h108);

        // 3: redirect with two stale responses in flight
        do_reset(32'h100);
        lat_mode = 3;
        wait_inflight2("t3_inflight");
        redir_mode = 0; redir_tgt = 32'h200; redir_req = 1;
        step();
        clear_log();
        repeat (12) step();
        check_deliv("t3_target", 0, 32'h200);

        // 4: redirect coinciding with response, pop request and non-empty buffer
        do_reset(32'h100);
        lat_mode = 1;
        redir_mode = 1; redir_tgt = 32'h300; redir_req = 1;
        for (int i = 0; i < 20 && redir_req; i++) step();
        if (redir_req) check("t4_timeout", 32'd0, 32'd1);
        clear_log();
        repeat (8) step();
        check_deliv("t4_target", 0, 32'h300);

        // 5: misaligned redirect target and PC wrap-around
        do_reset(32'h100);
        lat_mode = 2;
        redir_mode = 0; redir_tgt = 32'h203; redir_req = 1;
        step();
        clear_log();
        repeat (10) step();
        check_deliv("t5_align0", 0, 32'h200);
        check_deliv("t5_align1", 1, 32'h204);
        do_reset(32'hFFFF_FFF8);
        lat_mode = 1;
        clear_log();
        repeat (10) step();
        check_deliv("t5_wrap0", 0, 32'hFFFF_FFF8);
        check_deliv("t5_wrap1", 1, 32'hFFFF_FFFC);
        check_deliv("t5_wrap2", 2, 32'h0000_0000);

        // 6: reset mid-stream with two requests outstanding
        do_reset(32'h100);
        lat_mode = 3;
        wait_inflight2("t6_inflight");
        do_reset(32'h100);
        clear_log();
        repeat (12) step();
        check_deliv("t6_restart", 0, 32'h100);

        // Random traffic with occasional redirects and one mid-run reset
        do_reset($urandom);
        lat_mode = 0; rdy_pct = 70; ifr_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset($urandom);
            if (!redir_req && $urandom_range(99) < 3) begin
                redir_mode = 0;
                redir_tgt  = $urandom;
                redir_req  = 1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
